gpio_cnt_multi: RTL and testbench
=================================

# gpio_cnt_multi

Multi-channel GPIO edge counter and responder used by the CW305 simulation benches. It is the parametrised successor of the single-channel GPIO counter. Each channel counts qualified edges on its `gpio_i` bit. On every `CntMax`-th edge it either toggles its `gpio_o` bit or emits a `PulseLen`-cycle pulse. This lets software under test exercise several GPIO loopback pairs, edge polarities and interrupt-style pulses in one bench instance.

## Interface
- `NumCh`, 4: number of independent channels, 1..32.
- `CntW`, 16: width of each channel's edge counter.
- `CntMax`, 16: edges per fire event, 1..2^CntW.
- `EdgeMode`, 0: qualified edge, shared by all channels. 0 = rising, 1 = falling, 2 = both.
- `PulseOut`, 0: output mode. 0 = toggle `gpio_o` on fire; 1 = drive a high pulse on fire.
- `PulseLen`, 4: pulse length in cycles when `PulseOut`=1, 1..2^16-1.
- `clk_i` in 1: system clock, rising-edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `gpio_i` in NumCh: channel inputs, asynchronous to `clk_i` when the synchroniser is built.
- `en_i` in NumCh: per-channel count enable.
- `clear_i` in NumCh: per-channel synchronous clear.
- `gpio_o` out NumCh: channel responses.
- `fire_o` out NumCh: one-cycle strobe per fire event.
- `ovf_o` out NumCh: sticky retrigger flag, meaningful in pulse mode only.
- `cnt_o` out NumCh*CntW: current edge counts. Channel c occupies `[c*CntW +: CntW]`.

## Operation
- Sampled input `s[c]` is `gpio_i[c]`, or its synchronised version (see Configuration).
- Previous-sample register `p[c]` loads `s[c]` every cycle, including during reset and while `en_i[c]`=0. This guarantees no spurious edge at reset release or at enable.
- Edge detection:
  - rising = `s & ~p`
  - falling = `~s & p`
  - both = `s ^ p`
- Qualified edge `e[c]` = edge & `en_i[c]` & ~`clear_i[c]`.
- Counter behaviour on `e[c]`:
  - If `cnt == CntMax-1`: `cnt` <= 0 and fire is asserted.
  - Otherwise: `cnt` <= `cnt+1`.
  - `cnt` never exceeds `CntMax-1`. Arithmetic is CntW-bit; the `CntMax-1` comparison is done at CntW bits.
- Fire, toggle mode: `gpio_o[c]` <= ~`gpio_o[c]`.
- Fire, pulse mode:
  - `gpio_o[c]` <= 1 and `tmr[c]` <= `PulseLen-1`.
  - While `gpio_o[c]`=1 with no new fire: if `tmr`=0 then `gpio_o` <= 0, else `tmr` decrements.
  - A fire while `gpio_o[c]`=1 reloads `tmr` (retrigger) and sets `ovf_o[c]`.
- `fire_o[c]` is registered and high for the single cycle in which `gpio_o` reflects that fire.
- `clear_i[c]`:
  - Sets `cnt`, `gpio_o`, `tmr`, `fire_o` and `ovf_o` of channel c to 0 in that cycle.
  - Takes priority over a coincident edge; that edge is discarded.
- Channels are fully independent; there are no shared resources.
- State per channel is implicit. IDLE is `gpio_o` low in pulse mode. On fire it moves to PULSE. It returns to IDLE when `tmr`=0. A fire or clear in PULSE reloads or exits respectively.

## Timing
- Reset (`rst_i`=1 at a clock edge) sets `cnt_o`, `gpio_o`, `fire_o`, `ovf_o` and `tmr` to 0. `p` is not reset; it tracks `s`.
- Latency without synchroniser: an input change first sampled at edge E updates `cnt_o`, `gpio_o` and `fire_o` at edge E. They are visible in the cycle after E.
- The synchroniser adds exactly 2 cycles.
- Minimum input pulse width, high or low: 1 clock cycle without synchroniser, 2 cycles with it. Narrower pulses may be missed.
- Pulse mode: `gpio_o` is high for exactly `PulseLen` cycles per isolated fire. A retrigger at the last high cycle extends it seamlessly, with no low gap.
- `en_i` and `clear_i` act in the cycle they are sampled.

## Configuration
- `GPIO_CNT_MULTI_SYNC_EN`, defined: each `gpio_i` bit passes through a 2-flop synchroniser before edge detection. The synchroniser flops have no reset and sample during reset. Latency +2 cycles.
- Undefined: `gpio_i` feeds edge detection directly. The input must already be synchronous to `clk_i`.

## Test plan
- Rising mode, CntMax=16, toggle mode, 16 rising pulses on ch0:
  - `cnt_o` steps 1..15 and then returns to 0.
  - `gpio_o[0]` goes 0→1 and `fire_o[0]` strobes once.
  - 32 pulses leave `gpio_o[0]`=0.
  - Other channels stay 0.
- EdgeMode=2, CntMax=3, 3 input transitions on ch1 → one fire; `cnt_o` is 1, 2, then 0.
- Pulse mode, PulseLen=4, CntMax=1:
  - One edge → `gpio_o` high for exactly 4 cycles and `ovf_o`=0.
  - A second edge at pulse cycle 3 → high for 2+4=6 cycles total and `ovf_o`=1 (sticky).
- `clear_i[2]` coincident with the 16th edge → no fire and `cnt`=0. The next 16 edges fire normally.
- `gpio_i` held high through reset, release reset → no count. With `en_i`=0, 5 edges → `cnt` stays 0. Re-enabling creates no edge.
- `rst_i` asserted mid-pulse with `cnt`=7 → all outputs 0 the next cycle. Counting restarts from 0 afterwards.

Source files
------------

// File: rtl/gpio_cnt_multi.sv
// gpio_cnt_multi
// Multi-channel GPIO edge counter and responder. Each channel counts qualified
// edges on its gpio_i bit. On every CntMax-th edge it fires: in toggle mode
// (PulseOut=0) gpio_o flips, and in pulse mode (PulseOut=1) gpio_o goes high
// for PulseLen cycles. A fire during an active pulse restarts the pulse and
// sets the sticky ovf_o flag.
//
// Optional feature macro: GPIO_CNT_MULTI_SYNC_EN. When it is defined, a 2-flop
// synchroniser is placed in front of edge detection, which adds 2 cycles of latency.
//
// Ports
//   clk_i     system clock, rising edge
//   rst_i     synchronous active-high reset
//   gpio_i    [NumCh]       channel inputs
//   en_i      [NumCh]       per-channel count enable
//   clear_i   [NumCh]       per-channel synchronous clear (wins over an edge)
//   gpio_o    [NumCh]       channel responses
//   fire_o    [NumCh]       one-cycle fire strobe, aligned with the gpio_o update
//   ovf_o     [NumCh]       sticky retrigger flag (pulse mode)
//   cnt_o     [NumCh*CntW]  edge counts, channel c at [c*CntW +: CntW]

module gpio_cnt_multi #(
  parameter int NumCh    = 4,
  parameter int CntW     = 16,
  parameter int CntMax   = 16,
  parameter int EdgeMode = 0,
  parameter int PulseOut = 0,
  parameter int PulseLen = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumCh-1:0]        gpio_i,
  input  logic [NumCh-1:0]        en_i,
  input  logic [NumCh-1:0]        clear_i,
  output logic [NumCh-1:0]        gpio_o,
  output logic [NumCh-1:0]        fire_o,
  output logic [NumCh-1:0]        ovf_o,
  output logic [NumCh*CntW-1:0]   cnt_o
);

  // Wrap compare is done at CntW bits, so CntMax = 2^CntW gives an all-ones top.
  localparam logic [CntW-1:0] CntTop  = CntW'(CntMax - 1);
  localparam logic [15:0]     TmrLoad = 16'(PulseLen - 1);

  logic [NumCh-1:0]           w_samp;
  logic [NumCh-1:0]           w_edge;
  logic [NumCh-1:0]           w_qual;
  logic [NumCh-1:0]           w_wrap;
  logic [NumCh-1:0]           w_fire;

  logic [NumCh-1:0]           r_prev;
  logic [NumCh-1:0][CntW-1:0] r_cnt;
  logic [NumCh-1:0][15:0]     r_tmr;
  logic [NumCh-1:0]           r_gpio;
  logic [NumCh-1:0]           r_fire;
  logic [NumCh-1:0]           r_ovf;

`ifdef GPIO_CNT_MULTI_SYNC_EN
  // No reset here: the chain must keep tracking the pin during reset.
  logic [NumCh-1:0] r_sync1;
  logic [NumCh-1:0] r_sync2;

  always_ff @(posedge clk_i) begin
    r_sync1 <= gpio_i;
    r_sync2 <= r_sync1;
  end

  assign w_samp = r_sync2;
`else
  assign w_samp = gpio_i;
`endif

  // The previous sample is never reset, so neither reset release nor a re-enable
  // can produce a false edge.
  always_ff @(posedge clk_i) begin
    r_prev <= w_samp;
  end

  always_comb begin
    w_edge = w_samp ^ r_prev;
    if (EdgeMode == 0) begin
      w_edge = w_samp & ~r_prev;
    end else if (EdgeMode == 1) begin
      w_edge = ~w_samp & r_prev;
    end
  end

  always_comb begin
    for (int c = 0; c < NumCh; c++) begin
      w_wrap[c] = (r_cnt[c] == CntTop);
    end
  end

  assign w_qual = w_edge & en_i & ~clear_i;
  assign w_fire = w_qual & w_wrap;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_tmr  <= '0;
      r_gpio <= '0;
      r_fire <= '0;
      r_ovf  <= '0;
    end else begin
      for (int c = 0; c < NumCh; c++) begin
        // w_fire is already masked by clear_i, so this strobe drops on a clear.
        r_fire[c] <= w_fire[c];
        if (clear_i[c]) begin
          r_cnt[c]  <= '0;
          r_tmr[c]  <= '0;
          r_gpio[c] <= 1'b0;
          r_ovf[c]  <= 1'b0;
        end else begin
          if (w_qual[c]) begin
            r_cnt[c] <= w_wrap[c] ? '0 : r_cnt[c] + 1'b1;
          end
          if (PulseOut == 0) begin
            if (w_fire[c]) begin
              r_gpio[c] <= ~r_gpio[c];
            end
          end else if (w_fire[c]) begin
            // A fire on an already-high output reloads the timer with no low gap.
            r_gpio[c] <= 1'b1;
            r_tmr[c]  <= TmrLoad;
            if (r_gpio[c]) begin
              r_ovf[c] <= 1'b1;
            end
          end else if (r_gpio[c]) begin
            if (r_tmr[c] == 16'd0) begin
              r_gpio[c] <= 1'b0;
            end else begin
              r_tmr[c] <= r_tmr[c] - 16'd1;
            end
          end
        end
      end
    end
  end

  assign gpio_o = r_gpio;
  assign fire_o = r_fire;
  assign ovf_o  = r_ovf;
  assign cnt_o  = r_cnt;

endmodule

// File: tb/tb_gpio_cnt_multi.sv
// Bench for gpio_cnt_multi. Four instances with different configurations share
// one stimulus. A behavioural model tracks each channel as a modulo edge count,
// a toggle bit and a "remaining high cycles" count. Every cycle, the DUT outputs
// are compared against that model.
module tb_gpio_cnt_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] gin, en, clr;

  logic [3:0]  go_a, fo_a, ov_a, go_b, fo_b, ov_b, go_c, fo_c, ov_c, go_d, fo_d, ov_d;
  logic [63:0] cnt_a, cnt_b, cnt_c;
  logic [11:0] cnt_d;

  gpio_cnt_multi #(.NumCh(4), .CntW(16), .CntMax(16), .EdgeMode(0), .PulseOut(0), .PulseLen(4)) u_a (
    .clk_i(clk), .rst_i(rst), .gpio_i(gin), .en_i(en), .clear_i(clr),
    .gpio_o(go_a), .fire_o(fo_a), .ovf_o(ov_a), .cnt_o(cnt_a));
  gpio_cnt_multi #(.NumCh(4), .CntW(16), .CntMax(3), .EdgeMode(2), .PulseOut(0), .PulseLen(4)) u_b (
    .clk_i(clk), .rst_i(rst), .gpio_i(gin), .en_i(en), .clear_i(clr),
    .gpio_o(go_b), .fire_o(fo_b), .ovf_o(ov_b), .cnt_o(cnt_b));
  gpio_cnt_multi #(.NumCh(4), .CntW(16), .CntMax(1), .EdgeMode(0), .PulseOut(1), .PulseLen(4)) u_c (
    .clk_i(clk), .rst_i(rst), .gpio_i(gin), .en_i(en), .clear_i(clr),
    .gpio_o(go_c), .fire_o(fo_c), .ovf_o(ov_c), .cnt_o(cnt_c));
  gpio_cnt_multi #(.NumCh(4), .CntW(3), .CntMax(8), .EdgeMode(1), .PulseOut(1), .PulseLen(1)) u_d (
    .clk_i(clk), .rst_i(rst), .gpio_i(gin), .en_i(en), .clear_i(clr),
    .gpio_o(go_d), .fire_o(fo_d), .ovf_o(ov_d), .cnt_o(cnt_d));

  logic [3:0]  dg[4], df[4], dov[4];
  logic [15:0] dcnt[4][4];

  always_comb begin
    dg[0] = go_a;  dg[1] = go_b;  dg[2] = go_c;  dg[3] = go_d;
    df[0] = fo_a;  df[1] = fo_b;  df[2] = fo_c;  df[3] = fo_d;
    dov[0] = ov_a; dov[1] = ov_b; dov[2] = ov_c; dov[3] = ov_d;
    for (int c = 0; c < 4; c++) begin
      dcnt[0][c] = cnt_a[c*16 +: 16];
      dcnt[1][c] = cnt_b[c*16 +: 16];
      dcnt[2][c] = cnt_c[c*16 +: 16];
      dcnt[3][c] = {13'd0, cnt_d[c*3 +: 3]};
    end
  end

  // Per-instance configuration, as seen by the model.
  int MAXV[4] = '{16, 3, 1, 8};
  int EM[4]   = '{0, 2, 0, 1};
  int PO[4]   = '{0, 0, 1, 1};
  int PL[4]   = '{4, 4, 4, 1};

  int  m_cnt[4][4];
  int  m_rem[4][4];
  bit  m_g[4][4], m_f[4][4], m_ov[4][4];
  bit  [3:0] pv;
  bit  [3:0] h1, h2;

  int checks = 0;
  int errors = 0;

  task automatic model_step();
    bit [3:0] s;
    bit       e;
`ifdef GPIO_CNT_MULTI_SYNC_EN
    s  = h2;
    h2 = h1;
    h1 = gin;
`else
    s = gin;
`endif
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        case (EM[k])
          0:       e = s[c] && !pv[c];
          1:       e = !s[c] && pv[c];
          default: e = s[c] != pv[c];
        endcase
        m_f[k][c] = 1'b0;
        if (rst || clr[c]) begin
          m_cnt[k][c] = 0;
          m_rem[k][c] = 0;
          m_g[k][c]   = 1'b0;
          m_ov[k][c]  = 1'b0;
        end else begin
          if (e && en[c]) begin
            m_cnt[k][c] = (m_cnt[k][c] + 1) % MAXV[k];
            m_f[k][c]   = (m_cnt[k][c] == 0);
          end
          if (PO[k] == 0) begin
            if (m_f[k][c]) m_g[k][c] = !m_g[k][c];
          end else begin
            if (m_f[k][c]) begin
              if (m_rem[k][c] > 0) m_ov[k][c] = 1'b1;
              m_rem[k][c] = PL[k];
            end else if (m_rem[k][c] > 0) begin
              m_rem[k][c] = m_rem[k][c] - 1;
            end
            m_g[k][c] = (m_rem[k][c] > 0);
          end
        end
      end
    end
    pv = s;
  endtask

  task automatic chk(input string nm, input int k, input int c, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d ch%0d got %0d want %0d at %0t", nm, k, c, act, exp, $time);
    end
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        chk("cnt",  k, c, int'(dcnt[k][c]), m_cnt[k][c]);
        chk("gpio", k, c, int'(dg[k][c]),   int'(m_g[k][c]));
        chk("fire", k, c, int'(df[k][c]),   int'(m_f[k][c]));
        chk("ovf",  k, c, int'(dov[k][c]),  int'(m_ov[k][c]));
      end
    end
  endtask

  task automatic step(input logic [3:0] g, input logic [3:0] e, input logic [3:0] cl, input logic r);
    gin = g; en = e; clr = cl; rst = r;
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  int hc;

  initial begin
    pv = '0; h1 = '0; h2 = '0;
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++) begin
        m_cnt[k][c] = 0; m_rem[k][c] = 0;
        m_g[k][c] = 0; m_f[k][c] = 0; m_ov[k][c] = 0;
      end

    // gpio held high through reset, then release: no count, no pulse
    for (int i = 0; i < 4; i++) step(4'hF, 4'hF, 4'h0, 1'b1);
    lit("rst_cnt", int'(dcnt[0][0]), 0);
    step(4'hF, 4'hF, 4'h0, 1'b0);
    lit("rel_no_cnt", int'(dcnt[0][0]), 0);
    lit("rel_no_pulse", int'(dg[2][0]), 0);
    step(4'h0, 4'hF, 4'hF, 1'b0);

    // 16 then 32 rising pulses on ch0, toggle mode
    for (int i = 1; i <= 16; i++) begin
      step(4'h1, 4'hF, 4'h0, 1'b0);
      if (i == 15) lit("cnt15", int'(dcnt[0][0]), 15);
      if (i == 16) begin
        lit("wrap_cnt", int'(dcnt[0][0]), 0);
        lit("wrap_fire", int'(df[0][0]), 1);
        lit("wrap_gpio", int'(dg[0][0]), 1);
      end
      step(4'h0, 4'hF, 4'h0, 1'b0);
      if (i == 16) lit("fire_once", int'(df[0][0]), 0);
    end
    for (int i = 0; i < 16; i++) begin
      step(4'h1, 4'hF, 4'h0, 1'b0);
      step(4'h0, 4'hF, 4'h0, 1'b0);
    end
    lit("gpio32", int'(dg[0][0]), 0);
    lit("others0", int'(dg[0][3:1]), 0);

    // both-edge mode, CntMax=3, on ch1
    step(4'h0, 4'hF, 4'hF, 1'b0);
    step(4'h2, 4'hF, 4'h0, 1'b0);
    lit("both_1", int'(dcnt[1][1]), 1);
    step(4'h0, 4'hF, 4'h0, 1'b0);
    lit("both_2", int'(dcnt[1][1]), 2);
    step(4'h2, 4'hF, 4'h0, 1'b0);
    lit("both_0", int'(dcnt[1][1]), 0);
    lit("both_fire", int'(df[1][1]), 1);

    // pulse mode, CntMax=1, PulseLen=4, on ch3
    step(4'h0, 4'hF, 4'hF, 1'b0);
    hc = 0;
    step(4'h8, 4'hF, 4'h0, 1'b0);
    if (dg[2][3]) hc++;
    for (int i = 0; i < 8; i++) begin
      step(4'h0, 4'hF, 4'h0, 1'b0);
      if (dg[2][3]) hc++;
    end
    lit("pulse_len", hc, 4);
    lit("pulse_ovf0", int'(dov[2][3]), 0);
    hc = 0;
    step(4'h8, 4'hF, 4'h0, 1'b0);
    if (dg[2][3]) hc++;
    step(4'h0, 4'hF, 4'h0, 1'b0);
    if (dg[2][3]) hc++;
    step(4'h8, 4'hF, 4'h0, 1'b0);
    if (dg[2][3]) hc++;
    for (int i = 0; i < 8; i++) begin
      step(4'h0, 4'hF, 4'h0, 1'b0);
      if (dg[2][3]) hc++;
    end
    lit("retrig_len", hc, 6);
    lit("retrig_ovf", int'(dov[2][3]), 1);

    // clear coincident with the 16th edge on ch2
    step(4'h0, 4'hF, 4'hF, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step(4'h4, 4'hF, 4'h0, 1'b0);
      step(4'h0, 4'hF, 4'h0, 1'b0);
    end
    lit("clr_pre15", int'(dcnt[0][2]), 15);
    step(4'h4, 4'hF, 4'h4, 1'b0);
    lit("clr_cnt", int'(dcnt[0][2]), 0);
    lit("clr_nofire", int'(df[0][2]), 0);
    step(4'h0, 4'hF, 4'h0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(4'h4, 4'hF, 4'h0, 1'b0);
      if (i == 15) lit("clr_after_fire", int'(df[0][2]), 1);
      step(4'h0, 4'hF, 4'h0, 1'b0);
    end

    // disabled channel ignores edges; re-enable with input high makes no edge
    step(4'h0, 4'hF, 4'hF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'h2, 4'hD, 4'h0, 1'b0);
      step(4'h0, 4'hD, 4'h0, 1'b0);
    end
    lit("dis_cnt", int'(dcnt[0][1]), 0);
    step(4'h2, 4'hD, 4'h0, 1'b0);
    step(4'h2, 4'hF, 4'h0, 1'b0);
    lit("reen_rise", int'(dcnt[0][1]), 0);
    lit("reen_both", int'(dcnt[1][1]), 0);

    // reset mid-pulse with cnt=7
    step(4'h0, 4'hF, 4'hF, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(4'h0, 4'hF, 4'h0, 1'b0);
      step(4'h1, 4'hF, 4'h0, 1'b0);
    end
    lit("pre_rst_cnt", int'(dcnt[0][0]), 7);
    lit("pre_rst_pulse", int'(dg[2][0]), 1);
    step(4'h0, 4'hF, 4'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      lit("rst_all_gpio", int'(dg[k]), 0);
      lit("rst_all_ovf", int'(dov[k]), 0);
      lit("rst_all_cnt", int'(dcnt[k][0]), 0);
    end
    step(4'h0, 4'hF, 4'h0, 1'b0);
    step(4'h1, 4'hF, 4'h0, 1'b0);
    lit("post_rst_cnt", int'(dcnt[0][0]), 1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(4'($urandom), 4'($urandom | $urandom),
           ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0,
           ($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
